branch_resolution_unit: RTL

- Consumer end of the branch predictor's IF/EX protocol.
- Captures each IF-stage prediction into an in-order in-flight queue. When the instruction resolves in EX, pops the matching entry and compares predicted next-PC with actual next-PC.
- On a mismatch, issues a one-cycle redirect/flush to fetch.
- Also drives the predictor's registered update interface and keeps branch and mispredict statistics.

---
 rtl/branch_resolution_unit_if.sv | 47 ++++
 rtl/branch_resolution_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit_if.sv
// Fetch/execute/predictor-update bundle between the branch resolution unit and its neighbours.
`timescale 1ns/1ps
interface branch_resolution_unit_if #(
  parameter int unsigned CNT_BITS = 32
);
  logic                if_valid;
  logic [31:0]         if_pc;
  logic                if_predict_taken;
  logic [31:0]         if_predict_target;
  logic                if_target_valid;
  logic                if_ready;

  logic                ex_valid;
  logic [31:0]         ex_pc;
  logic                ex_is_branch;
  logic                ex_branch_taken;
  logic [31:0]         ex_target;

  logic                redirect_valid;
  logic [31:0]         redirect_pc;

  logic                update_enable;
  logic [31:0]         update_pc;
  logic [31:0]         update_target;
  logic                update_is_branch;
  logic                update_taken;

  logic [CNT_BITS-1:0] branch_count;
  logic [CNT_BITS-1:0] mispredict_count;
  logic                sync_error;

  modport master (
    output if_valid, if_pc, if_predict_taken, if_predict_target, if_target_valid,
    output ex_valid, ex_pc, ex_is_branch, ex_branch_taken, ex_target,
    input  if_ready, redirect_valid, redirect_pc,
    input  update_enable, update_pc, update_target, update_is_branch, update_taken,
    input  branch_count, mispredict_count, sync_error
  );

  modport slave (
    input  if_valid, if_pc, if_predict_taken, if_predict_target, if_target_valid,
    input  ex_valid, ex_pc, ex_is_branch, ex_branch_taken, ex_target,
    output if_ready, redirect_valid, redirect_pc,
    output update_enable, update_pc, update_target, update_is_branch, update_taken,
    output branch_count, mispredict_count, sync_error
  );
endinterface

// File: rtl/branch_resolution_unit.sv
// Tracks in-flight fetch predictions, checks them against EX resolution, and issues
// fetch redirects, predictor updates and branch/mispredict statistics.
`timescale 1ns/1ps
module branch_resolution_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_BITS = 2,
  parameter int unsigned CNT_BITS = 32
) (
  input logic                     clock,
  input logic                     reset,
  branch_resolution_unit_if.slave bus
);

  localparam int unsigned PW = PTR_BITS + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        eff_taken;
    logic [31:0] eff_target;
  } entry_t;

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  entry_t              mem_q [DEPTH];

  logic                ready_q, ready_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [31:0]         redirect_pc_q, redirect_pc_d;
  logic                upd_en_q, upd_en_d;
  logic [31:0]         upd_pc_q, upd_pc_d;
  logic [31:0]         upd_tgt_q, upd_tgt_d;
  logic                upd_br_q, upd_br_d;
  logic                upd_tk_q, upd_tk_d;
  logic [CNT_BITS-1:0] bcnt_q, bcnt_d;
  logic [CNT_BITS-1:0] mcnt_q, mcnt_d;
  logic                sync_err_q, sync_err_d;

  entry_t      head_e;
  logic        empty;
  logic        pop;
  logic        push;
  logic        pc_mismatch;
  logic        mispredict;
  logic [31:0] pred_next;
  logic [31:0] actual_next;

  // Head-of-queue comparison; a PC mismatch forces a redirect even if next-PCs agree
  assign head_e      = mem_q[head_q[PTR_BITS-1:0]];
  assign empty       = (head_q == tail_q);
  assign pred_next   = head_e.eff_taken ? head_e.eff_target : 32'(head_e.pc + 32'd4);
  assign actual_next = (bus.ex_is_branch & bus.ex_branch_taken) ? bus.ex_target
                                                                  : 32'(bus.ex_pc + 32'd4);
  assign pop         = (state_q == RUN) & bus.ex_valid & ~empty;
  assign pc_mismatch = pop & (head_e.pc != bus.ex_pc);
  assign mispredict  = pop & ((pred_next != actual_next) | (head_e.pc != bus.ex_pc));
  assign push        = bus.if_valid & ready_q & ~mispredict;

  // Queue storage needs no reset: entries are only read between head and tail
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[tail_q[PTR_BITS-1:0]] <= '{pc:         bus.if_pc,
                                       eff_taken:  bus.if_predict_taken & bus.if_target_valid,
                                       eff_target: bus.if_predict_target};
    end
  end

  always_comb begin
    state_d          = state_q;
    head_d           = head_q;
    tail_d           = tail_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;
    upd_en_d         = 1'b0;
    upd_pc_d         = '0;
    upd_tgt_d        = '0;
    upd_br_d         = 1'b0;
    upd_tk_d         = 1'b0;
    bcnt_d           = bcnt_q;
    mcnt_d           = mcnt_q;
    sync_err_d       = sync_err_q;
    ready_d          = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.ex_valid & empty) begin
          sync_err_d = 1'b1;
        end
        if (pop) begin
          head_d    = PW'(head_q + PW'(1));
          upd_en_d  = bus.ex_is_branch;
          upd_pc_d  = bus.ex_pc;
          upd_tgt_d = bus.ex_target;
          upd_br_d  = bus.ex_is_branch;
          upd_tk_d  = bus.ex_branch_taken;
          if (bus.ex_is_branch && (bcnt_q != '1)) begin
            bcnt_d = CNT_BITS'(bcnt_q + CNT_BITS'(1));
          end
        end
        if (pc_mismatch) begin
          sync_err_d = 1'b1;
        end
        if (push) begin
          tail_d = PW'(tail_q + PW'(1));
        end
        // Wrong-path entries behind the mispredict are dropped by collapsing head onto tail
        if (mispredict) begin
          state_d          = REDIRECT;
          head_d           = tail_q;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = actual_next;
          if (mcnt_q != '1) begin
            mcnt_d = CNT_BITS'(mcnt_q + CNT_BITS'(1));
          end
        end
      end
      REDIRECT: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    ready_d = (state_d == RUN) &
              ~((head_d[PTR_BITS-1:0] == tail_d[PTR_BITS-1:0]) &
                (head_d[PTR_BITS] != tail_d[PTR_BITS]));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= RUN;
      head_q           <= '0;
      tail_q           <= '0;
      ready_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_en_q         <= 1'b0;
      upd_pc_q         <= '0;
      upd_tgt_q        <= '0;
      upd_br_q         <= 1'b0;
      upd_tk_q         <= 1'b0;
      bcnt_q           <= '0;
      mcnt_q           <= '0;
      sync_err_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      ready_q          <= ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      upd_en_q         <= upd_en_d;
      upd_pc_q         <= upd_pc_d;
      upd_tgt_q        <= upd_tgt_d;
      upd_br_q         <= upd_br_d;
      upd_tk_q         <= upd_tk_d;
      bcnt_q           <= bcnt_d;
      mcnt_q           <= mcnt_d;
      sync_err_q       <= sync_err_d;
    end
  end

  assign bus.if_ready         = ready_q;
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.update_enable    = upd_en_q;
  assign bus.update_pc        = upd_pc_q;
  assign bus.update_target    = upd_tgt_q;
  assign bus.update_is_branch = upd_br_q;
  assign bus.update_taken     = upd_tk_q;
  assign bus.branch_count     = bcnt_q;
  assign bus.mispredict_count = mcnt_q;
  assign bus.sync_error       = sync_err_q;

endmodule
